imem_loader_arbiter: RTL and testbench
======================================

Name: imem_loader_arbiter

Overview:
Owns the single port of the instruction distributed memory (8-bit word address, 32-bit data, async read, sync write with clock enable). Arbitrates between two users:
- a byte-stream program loader (debug/UART side);
- the CPU fetch stage.
Packs loader bytes into 32-bit words. Translates the CPU's byte-addressed PC into a word index, so PC+4 maps to the next memory word.

Parameters:
ADDR_W, 8, memory word-address width (depth 2^ADDR_W words)
DATA_W, 32, memory/instruction width (fixed at 32)
PC_W, 32, CPU program counter width

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_load_start  in  1  pulse: enter LOAD, clear pointer/flags
i_byte_valid  in  1  loader byte strobe
i_byte  in  8  loader byte, first byte of word = bits[31:24]
o_byte_ready  out  1  byte accepted this cycle when high with i_byte_valid
i_load_done  in  1  pulse: end of program image
i_pc  in  PC_W  CPU byte address
i_fetch_en  in  1  CPU fetch request
o_instr  out  32  fetched instruction
o_instr_valid  out  1  o_instr valid this cycle
o_cpu_stall  out  1  CPU must hold PC
o_mem_a  out  ADDR_W  memory address
o_mem_d  out  32  memory write data
o_mem_we  out  1  memory write enable
o_mem_ce  out  1  memory clock enable
i_mem_spo  in  32  memory async read data
o_loaded_words  out  ADDR_W+1  words written in the current image
o_overflow  out  1  sticky: bytes dropped because memory was full
o_state  out  2  IDLE=00, LOAD=01, FLUSH=10, RUN=11

Behaviour:
- Reset (async assert, sync release): state IDLE. Outputs cleared: byte pointer, wr_ptr, o_loaded_words, o_overflow, o_mem_we, o_mem_ce, o_instr_valid, o_byte_ready. o_cpu_stall=1.
- IDLE: memory idle (ce=0, we=0), o_cpu_stall=1. i_load_start -> LOAD.
- LOAD, byte packing:
  - o_byte_ready=1 except during the write cycle.
  - Each accepted byte shifts into a 4-byte packer; byte count 0..3.
  - Byte order is big-endian: byte0 -> [31:24], byte3 -> [7:0].
- LOAD, word write:
  - On the 4th byte, the next cycle is the write cycle: o_mem_a=wr_ptr, o_mem_d=packed word, o_mem_we=1, o_mem_ce=1, o_byte_ready=0.
  - After the write cycle, wr_ptr++ and o_loaded_words++.
- Full memory: when o_loaded_words = 2^ADDR_W, bytes are still acknowledged but discarded, and o_overflow is set. o_overflow stays set until the next i_load_start. wr_ptr never wraps.
- i_load_done -> FLUSH. If i_byte_valid is accepted in the same cycle, that byte is packed first.
- FLUSH, partial word (1-3 bytes): zero-pad the low bytes and write the word in one cycle, unless memory is full. Then go to RUN.
- FLUSH, no partial word: go to RUN in the next cycle. FLUSH lasts exactly 1 cycle.
- RUN, combinational fetch path:
  - o_cpu_stall=0, o_mem_we=0.
  - o_mem_a=i_pc[ADDR_W+1:2]; i_pc[1:0] and bits above ADDR_W+1 are ignored.
  - o_mem_ce=i_fetch_en, o_instr=i_mem_spo, o_instr_valid=i_fetch_en. Zero latency.
- i_load_start in any non-IDLE state -> LOAD. It clears the packer, wr_ptr, o_loaded_words and o_overflow, and aborts any in-progress write (no we in the following cycle).
- Priority when pulses coincide: i_load_start > i_load_done > byte. i_load_done outside LOAD is ignored.
- Reset mid-write: we drops immediately, which may corrupt the target word. This is accepted.
- o_cpu_stall=1 in every state except RUN.

Optional Feature:
IMEM_BOUNDS_CHECK_EN
- Defined: adds output o_pc_oob (1 bit).
  - In RUN with i_fetch_en, if word index >= o_loaded_words: o_instr=32'h0000_0000 (NOP), o_pc_oob=1, o_mem_ce=0.
  - Otherwise o_pc_oob=0. o_pc_oob=0 outside RUN and at reset.
- Undefined: no o_pc_oob port; reads past the image return raw memory contents.

Test Plan:
- Reset, then load 8 bytes AA,AA,BB,BB,CC,CC,DD,DD, then i_load_done -> writes word0=AAAABBBB and word1=CCCCDDDD, o_loaded_words=2, state RUN after 1 FLUSH cycle.
- In RUN, i_pc = 0, 4, 8 with i_fetch_en=1 -> o_mem_a = 0, 1, 2. o_instr follows memory contents in the same cycle; o_cpu_stall=0.
- Load 6 bytes 11,22,33,44,55,66, then done -> word1 = 55660000, o_loaded_words=2.
- With ADDR_W=2, stream 20 bytes -> 4 words written, o_overflow=1, no write to address 0 after wrap. Next i_load_start clears o_overflow.
- i_load_start asserted in RUN and in mid-word LOAD (2 bytes packed) -> stall=1, packer/pointer cleared. The next 4 bytes land at address 0.
- With IMEM_BOUNDS_CHECK_EN, 2 words loaded: i_pc=8 -> o_instr=0, o_pc_oob=1. i_pc=4 -> o_pc_oob=0.

Source files
------------

// File: rtl/imem_loader_arbiter.sv
`timescale 1ns/1ps
// Owns the single instruction-memory port: packs loader bytes into big-endian words,
// then serves zero-latency CPU fetches. Optional macro: IMEM_BOUNDS_CHECK_EN (adds o_pc_oob).
module imem_loader_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    input  logic              i_load_done,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_fetch_en,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    output logic              o_cpu_stall,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [DATA_W-1:0] o_mem_d,
    output logic              o_mem_we,
    output logic              o_mem_ce,
    input  logic [DATA_W-1:0] i_mem_spo,
    output logic [ADDR_W:0]   o_loaded_words,
    output logic              o_overflow,
`ifdef IMEM_BOUNDS_CHECK_EN
    output logic              o_pc_oob,
`endif
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        FLUSH = 2'b10,
        RUN   = 2'b11
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [DATA_W-1:0] packer;
    logic [1:0]        byte_cnt;
    logic              wr_pend;     // current cycle is a memory write cycle

    logic              full;
    logic              byte_acc;
    logic              pack_acc;
    logic              word_done;
    logic [DATA_W-1:0] next_packer;
    logic [1:0]        next_cnt;
    logic [DATA_W-1:0] flush_word;
    logic [ADDR_W-1:0] fetch_idx;
    logic              unused_pc_bits;

    assign full         = (o_loaded_words == FULL_CNT);
    assign o_byte_ready = (state == LOAD) && !wr_pend;
    assign byte_acc     = o_byte_ready && i_byte_valid && !i_load_start;
    assign pack_acc     = byte_acc && !full;
    assign word_done    = pack_acc && (byte_cnt == 2'd3);
    assign next_packer  = pack_acc ? {packer[23:0], i_byte} : packer;
    assign next_cnt     = pack_acc ? byte_cnt + 2'd1 : byte_cnt;
    assign o_cpu_stall  = (state != RUN);
    assign o_state      = state;
    assign fetch_idx    = i_pc[ADDR_W+1:2];
    assign unused_pc_bits = ^{i_pc[PC_W-1:ADDR_W+2], i_pc[1:0]};

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        flush_word = next_packer;
        case (next_cnt)
            2'd1:    flush_word = {next_packer[7:0],  24'h0};
            2'd2:    flush_word = {next_packer[15:0], 16'h0};
            2'd3:    flush_word = {next_packer[23:0], 8'h0};
            default: flush_word = next_packer;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            packer         <= '0;
            byte_cnt       <= '0;
            wr_pend        <= 1'b0;
            o_loaded_words <= '0;
            o_overflow     <= 1'b0;
        end else begin
            if (wr_pend) begin
                wr_pend        <= 1'b0;
                o_loaded_words <= o_loaded_words + (ADDR_W+1)'(1);
            end
            if (i_load_start) begin
                // Restart the image from word 0, dropping any write queued for next cycle.
                state          <= LOAD;
                packer         <= '0;
                byte_cnt       <= '0;
                wr_pend        <= 1'b0;
                o_loaded_words <= '0;
                o_overflow     <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (byte_acc && full) o_overflow <= 1'b1;
                        packer   <= next_packer;
                        byte_cnt <= next_cnt;
                        if (word_done) wr_pend <= 1'b1;
                        if (i_load_done) begin
                            state    <= FLUSH;
                            packer   <= flush_word;
                            byte_cnt <= '0;
                            if (next_cnt != 2'd0 && !full) wr_pend <= 1'b1;
                        end
                    end
                    FLUSH:   state <= RUN;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_mem_a       = o_loaded_words[ADDR_W-1:0];
        o_mem_d       = packer;
        o_mem_we      = wr_pend;
        o_mem_ce      = wr_pend;
        o_instr       = '0;
        o_instr_valid = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
        o_pc_oob      = 1'b0;
`endif
        if (state == RUN) begin
            o_mem_a       = fetch_idx;
            o_mem_we      = 1'b0;
            o_mem_ce      = i_fetch_en;
            o_instr       = i_mem_spo;
            o_instr_valid = i_fetch_en;
`ifdef IMEM_BOUNDS_CHECK_EN
            if (i_fetch_en && ({1'b0, fetch_idx} >= o_loaded_words)) begin
                o_pc_oob = 1'b1;
                o_instr  = '0;
                o_mem_ce = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for imem_loader_arbiter (ADDR_W=2): expected memory writes and fetches
// are queued by the stimulus and popped by a negedge monitor; status is checked directly.
module tb_imem_loader_arbiter;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       instr;
        logic              oob;
    } fetch_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start, byte_valid, load_done, fetch_en;
    logic [7:0]        byte_in;
    logic              byte_ready;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic              instr_valid, cpu_stall;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_d, mem_spo;
    logic              mem_we, mem_ce;
    logic [ADDR_W:0]   loaded_words;
    logic              overflow;
    logic [1:0]        state;
`ifdef IMEM_BOUNDS_CHECK_EN
    logic              pc_oob;
`endif

    logic [31:0] mem [1<<ADDR_W];
    wr_t         exp_wr[$];
    fetch_t      exp_fetch[$];
    int          checks = 0;
    int          errors = 0;

    imem_loader_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start),
        .i_byte_valid(byte_valid), .i_byte(byte_in), .o_byte_ready(byte_ready),
        .i_load_done(load_done), .i_pc(pc), .i_fetch_en(fetch_en),
        .o_instr(instr), .o_instr_valid(instr_valid), .o_cpu_stall(cpu_stall),
        .o_mem_a(mem_a), .o_mem_d(mem_d), .o_mem_we(mem_we), .o_mem_ce(mem_ce),
        .i_mem_spo(mem_spo), .o_loaded_words(loaded_words), .o_overflow(overflow),
`ifdef IMEM_BOUNDS_CHECK_EN
        .o_pc_oob(pc_oob),
`endif
        .o_state(state)
    );

    always #5 clk = ~clk;

    // Distributed-RAM model: async read, sync write with clock enable.
    assign mem_spo = mem[mem_a];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (mem_ce && mem_we) begin
            mem[mem_a] <= mem_d;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT drives a write or a fetch.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got a=%0d d=%h expected no write", mem_a, mem_d);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_a), 32'(e.a));
                    check("wr_data", mem_d, e.d);
                    check("wr_ce", 32'(mem_ce), 32'd1);
                end
            end
            if (instr_valid) begin
                if (exp_fetch.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: got a=%0d instr=%h expected none", mem_a, instr);
                end else begin
                    fetch_t f;
                    f = exp_fetch.pop_front();
                    check("fetch_addr", 32'(mem_a), 32'(f.a));
                    check("fetch_instr", instr, f.instr);
                    check("fetch_ce", 32'(mem_ce), 32'(!f.oob));
                    check("fetch_stall", 32'(cpu_stall), 32'd0);
`ifdef IMEM_BOUNDS_CHECK_EN
                    check("fetch_oob", 32'(pc_oob), 32'(f.oob));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a; e.d = d;
        exp_wr.push_back(e);
    endtask

    // raw is the memory word; in_image says whether the word lies inside the loaded image.
    task automatic fetch(input logic [31:0] addr_pc, input logic [ADDR_W-1:0] a,
                         input logic [31:0] raw, input logic in_image);
        fetch_t f;
        f.a = a;
`ifdef IMEM_BOUNDS_CHECK_EN
        f.instr = in_image ? raw : 32'h0;
        f.oob   = !in_image;
`else
        f.instr = raw;
        f.oob   = 1'b0;
`endif
        exp_fetch.push_back(f);
        pc = addr_pc; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1; byte_in = b;
        while (!byte_ready && n < 10) begin tick(); n++; end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL byte_ready_timeout: got ready=0 expected ready=1 within 10 cycles");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1; tick(); load_start = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1; tick(); load_done = 1'b0;
        check("state_flush", 32'(state), 32'd2);
        tick();
        check("state_run", 32'(state), 32'd3);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h0;
        load_done = 1'b0; fetch_en = 1'b0; pc = '0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd1);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_loaded", 32'(loaded_words), 32'd0);
        check("rst_mem_ctl", {30'd0, mem_we, mem_ce}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_stall", 32'(cpu_stall), 32'd1);

        // Two full words, done after the second write.
        pulse_start();
        check("load_state", 32'(state), 32'd1);
        check("load_ready", 32'(byte_ready), 32'd1);
        push_wr(2'd0, 32'hAAAA_BBBB);
        push_wr(2'd1, 32'hCCCC_DDDD);
        foreach (byte_in_seq1[i]) send_byte(byte_in_seq1[i]);
        tick();
        finish_load();
        check("loaded_2", 32'(loaded_words), 32'd2);
        check("run_stall", 32'(cpu_stall), 32'd0);
        fetch(32'h0000_0000, 2'd0, 32'hAAAA_BBBB, 1'b1);
        fetch(32'h0000_0004, 2'd1, 32'hCCCC_DDDD, 1'b1);
        fetch(32'h0000_0106, 2'd1, 32'hCCCC_DDDD, 1'b1);
        fetch(32'h0000_0008, 2'd2, 32'hDEAD_0002, 1'b0);

        // Restart from RUN; 6 bytes leave a 2-byte partial word flushed with zero padding.
        pulse_start();
        check("restart_stall", 32'(cpu_stall), 32'd1);
        check("restart_loaded", 32'(loaded_words), 32'd0);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        push_wr(2'd0, 32'h1122_3344);
        push_wr(2'd1, 32'h5566_0000);
        for (int i = 1; i <= 6; i++) send_byte(8'(8'h11 * i));
        finish_load();
        check("loaded_partial", 32'(loaded_words), 32'd2);

        // Final byte and done in the same cycle: byte is packed before the flush.
        pulse_start();
        push_wr(2'd0, 32'h0102_0304);
        for (int i = 1; i <= 3; i++) send_byte(8'(i));
        byte_valid = 1'b1; byte_in = 8'h04; load_done = 1'b1;
        tick();
        byte_valid = 1'b0; load_done = 1'b0;
        check("state_flush_coinc", 32'(state), 32'd2);
        tick();
        check("loaded_coinc", 32'(loaded_words), 32'd1);

        // 20 bytes into a 4-word memory: last 4 bytes dropped, no wrap to address 0.
        pulse_start();
        for (int w = 0; w < 4; w++)
            push_wr(2'(w), {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        tick();
        check("full_loaded", 32'(loaded_words), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        finish_load();
        check("overflow_sticky", 32'(overflow), 32'd1);
        pulse_start();
        check("overflow_clear", 32'(overflow), 32'd0);
        check("ptr_clear", 32'(loaded_words), 32'd0);

        // load_start together with a 4th byte: the byte and its write are discarded.
        for (int i = 0; i < 3; i++) send_byte(8'h31 + 8'(i));
        byte_valid = 1'b1; byte_in = 8'h34; load_start = 1'b1;
        tick();
        byte_valid = 1'b0; load_start = 1'b0;
        check("abort_ready", 32'(byte_ready), 32'd1);
        tick();
        check("abort_loaded", 32'(loaded_words), 32'd0);

        // Abort with two bytes packed; the next word must start clean at address 0.
        send_byte(8'hE1); send_byte(8'hE2);
        pulse_start();
        check("midword_state", 32'(state), 32'd1);
        push_wr(2'd0, 32'hF1F2_F3F4);
        for (int i = 1; i <= 4; i++) send_byte(8'hF0 + 8'(i));
        tick();
        finish_load();
        check("midword_loaded", 32'(loaded_words), 32'd1);
        fetch(32'h0000_0000, 2'd0, 32'hF1F2_F3F4, 1'b1);
        fetch(32'h0000_0004, 2'd1, 32'h0405_0607, 1'b0);

        tick(); tick();
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic [7:0] byte_in_seq1 [8] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD};

endmodule
